// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction handshake, ALU drive/return, writeback and debug signals of alu_issue_stage.
// Flag outputs exist only when ALU_STAGE_FLAGS_EN is defined.
interface alu_issue_if #(
    parameter int WIDTH = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      in_instr;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_c;
    logic             wb_valid;
    logic [2:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic             div0;
    logic [2:0]       dbg_addr;
    logic [WIDTH-1:0] dbg_data;
`ifdef ALU_STAGE_FLAGS_EN
    logic             flag_z;
    logic             flag_n;
`endif

    modport master (
        output in_valid, in_instr, alu_c, dbg_addr,
        input  in_ready, alu_a, alu_b, alu_sel, wb_valid, wb_addr, wb_data, div0, dbg_data
`ifdef ALU_STAGE_FLAGS_EN
        , input flag_z, flag_n
`endif
    );

    modport slave (
        input  in_valid, in_instr, alu_c, dbg_addr,
        output in_ready, alu_a, alu_b, alu_sel, wb_valid, wb_addr, wb_data, div0, dbg_data
`ifdef ALU_STAGE_FLAGS_EN
        , output flag_z, flag_n
`endif
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: 4-cycle operand-fetch/issue/writeback stage around an external 24-bit ALU.
// Define ALU_STAGE_FLAGS_EN to add zero/negative flags of the captured result.
module alu_issue_stage #(
    parameter int NREGS = 8,
    parameter int WIDTH = 24
) (
    input logic        clk,
    input logic        rst_n,
    alu_issue_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] EX   = 2'd2;
    localparam logic [1:0] WB   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [23:0]      instr_q, instr_d;
    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] rf_d [NREGS];
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [2:0]       wb_addr_q, wb_addr_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic             div0_q, div0_d;
    logic             div_zero;
    logic [WIDTH-1:0] result;
`ifdef ALU_STAGE_FLAGS_EN
    logic             flag_z_q, flag_z_d, flag_n_q, flag_n_d;
`endif

    always_comb begin
        div_zero  = alu_sel_q == 3'b101 && alu_b_q == '0;
        result    = div_zero ? '1 : bus.alu_c;
        state_d   = state_q;
        instr_d   = instr_q;
        rf_d      = rf_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        div0_d    = div0_q;
`ifdef ALU_STAGE_FLAGS_EN
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
`endif
        case (state_q)
            IDLE: begin
                instr_d = bus.in_valid ? bus.in_instr : instr_q;
                state_d = bus.in_valid ? RD : IDLE;
            end
            RD: begin
                alu_a_d   = rf_q[instr_q[17:15]];
                alu_b_d   = instr_q[11] ? {{(WIDTH-11){1'b0}}, instr_q[10:0]} : rf_q[instr_q[14:12]];
                alu_sel_d = instr_q[23:21];
                state_d   = EX;
            end
            EX: begin
                wb_data_d = result;
                wb_addr_d = instr_q[20:18];
                div0_d    = div0_q | div_zero;
`ifdef ALU_STAGE_FLAGS_EN
                flag_z_d  = result == '0;
                flag_n_d  = result[WIDTH-1];
`endif
                state_d   = WB;
            end
            default: begin
                // r0 stays zero; the pulse is still reported on the bus
                if (wb_addr_q != 3'd0) rf_d[wb_addr_q] = wb_data_q;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            rf_q      <= '{default: '0};
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            div0_q    <= 1'b0;
`ifdef ALU_STAGE_FLAGS_EN
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            rf_q      <= rf_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            div0_q    <= div0_d;
`ifdef ALU_STAGE_FLAGS_EN
            flag_z_q  <= flag_z_d;
            flag_n_q  <= flag_n_d;
`endif
        end
    end

    assign bus.in_ready = state_q == IDLE;
    assign bus.wb_valid = state_q == WB;
    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_sel  = alu_sel_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.div0     = div0_q;
    assign bus.dbg_data = rf_q[bus.dbg_addr];
`ifdef ALU_STAGE_FLAGS_EN
    assign bus.flag_z   = flag_z_q;
    assign bus.flag_n   = flag_n_q;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random instructions checked against an architectural register-file model.
// Honours ALU_STAGE_FLAGS_EN for the optional flag outputs.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [23:0] m_rf [8];
    logic        m_div0;
    logic        m_z, m_n;

    alu_issue_if bus ();

    alu_issue_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // the external ALU; a zero divisor returns junk the stage must ignore
    function automatic logic [23:0] alu_fn(input logic [2:0] op, input logic [23:0] a, input logic [23:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a - b;
            3'd4: return 24'((48'(a) * 48'(b)));
            3'd5: return (b == 24'd0) ? 24'h123456 : a / b;
            3'd6: return (b >= 24'd24) ? 24'd0 : a << b;
            default: return 24'($signed(a) >>> ((b >= 24'd24) ? 24'd23 : b));
        endcase
    endfunction

    assign bus.alu_c = alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b);

    function automatic logic [23:0] mk(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                       input logic [2:0] rs2, input logic is_imm, input logic [10:0] imm);
        return {op, rd, rs1, rs2, is_imm, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_div0 = 1'b0;
        m_z = 1'b0;
        m_n = 1'b0;
    endtask

    // called at a negedge with the stage idle; returns at a negedge with the stage idle again
    task automatic issue(input logic [23:0] ins);
        logic [2:0]  op, rd;
        logic [23:0] a, b, res;
        logic        dz;
        op  = ins[23:21];
        rd  = ins[20:18];
        a   = m_rf[ins[17:15]];
        b   = ins[11] ? {13'd0, ins[10:0]} : m_rf[ins[14:12]];
        dz  = op == 3'd5 && b == 24'd0;
        res = dz ? 24'hFFFFFF : alu_fn(op, a, b);
        bus.dbg_addr = rd;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        chk("ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_instr = 24'($urandom);
        @(negedge clk);
        chk("ready_rd", 32'(bus.in_ready), 32'd0);
        chk("wbv_rd", 32'(bus.wb_valid), 32'd0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("alu_a", 32'(bus.alu_a), 32'(a));
        chk("alu_b", 32'(bus.alu_b), 32'(b));
        chk("alu_sel", 32'(bus.alu_sel), 32'(op));
        chk("ready_ex", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        m_div0 = m_div0 | dz;
        m_z = res == 24'd0;
        m_n = res[23];
        chk("wbv_wb", 32'(bus.wb_valid), 32'd1);
        chk("wb_addr", 32'(bus.wb_addr), 32'(rd));
        chk("wb_data", 32'(bus.wb_data), 32'(res));
        chk("div0", 32'(bus.div0), 32'(m_div0));
`ifdef ALU_STAGE_FLAGS_EN
        chk("flag_z", 32'(bus.flag_z), 32'(m_z));
        chk("flag_n", 32'(bus.flag_n), 32'(m_n));
`endif
        if (rd != 3'd0) m_rf[rd] = res;
        @(negedge clk);
        chk("wbv_after", 32'(bus.wb_valid), 32'd0);
        chk("ready_after", 32'(bus.in_ready), 32'd1);
        chk("dbg_rd", 32'(bus.dbg_data), 32'(m_rf[rd]));
    endtask

    initial begin
        logic [23:0] r7_before;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.dbg_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_wbv", 32'(bus.wb_valid), 32'd0);
        chk("rst_a", 32'(bus.alu_a), 32'd0);
        chk("rst_b", 32'(bus.alu_b), 32'd0);
        chk("rst_sel", 32'(bus.alu_sel), 32'd0);
        chk("rst_wba", 32'(bus.wb_addr), 32'd0);
        chk("rst_wbd", 32'(bus.wb_data), 32'd0);
        chk("rst_div0", 32'(bus.div0), 32'd0);
`ifdef ALU_STAGE_FLAGS_EN
        chk("rst_fz", 32'(bus.flag_z), 32'd0);
        chk("rst_fn", 32'(bus.flag_n), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        // in_valid low: stage must stay idle
        @(negedge clk);
        chk("idle_hold", 32'(bus.in_ready), 32'd1);

        issue(mk(3'd2, 3'd1, 3'd0, 3'd0, 1'b1, 11'd5));
        issue(mk(3'd2, 3'd2, 3'd0, 3'd0, 1'b1, 11'd3));
        issue(mk(3'd2, 3'd3, 3'd1, 3'd2, 1'b0, 11'd0));
        chk("add_r3", 32'(m_rf[3]), 32'd8);
        issue(mk(3'd3, 3'd4, 3'd2, 3'd1, 1'b0, 11'd0));
        chk("sub_r4", 32'(m_rf[4]), 32'hFFFFFE);
        issue(mk(3'd5, 3'd5, 3'd1, 3'd0, 1'b0, 11'd0));
        chk("div0_r5", 32'(m_rf[5]), 32'hFFFFFF);
        issue(mk(3'd2, 3'd0, 3'd0, 3'd0, 1'b1, 11'd7));
        issue(mk(3'd6, 3'd6, 3'd1, 3'd0, 1'b1, 11'd24));
        issue(mk(3'd7, 3'd6, 3'd4, 3'd0, 1'b1, 11'd4));

        for (int i = 0; i < 40; i++) issue(24'($urandom));
        chk("div0_sticky", 32'(bus.div0), 32'd1);

        r7_before = m_rf[7];
        bus.dbg_addr = 3'd7;
        bus.in_instr = mk(3'd2, 3'd7, 3'd7, 3'd0, 1'b1, 11'd1);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("hold_ready_%0d", i), 32'(bus.in_ready), 32'(i % 4 == 0));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        m_rf[7] = r7_before + 24'd3;
        chk("hold_r7", 32'(bus.dbg_data), 32'(m_rf[7]));
        chk("hold_ready_end", 32'(bus.in_ready), 32'd1);

        issue(mk(3'd2, 3'd1, 3'd0, 3'd0, 1'b1, 11'd5));
        issue(mk(3'd2, 3'd2, 3'd0, 3'd0, 1'b1, 11'd3));
        bus.dbg_addr = 3'd1;
        bus.in_instr = mk(3'd4, 3'd6, 3'd1, 3'd2, 1'b0, 11'd0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_sel", 32'(bus.alu_sel), 32'd4);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_wbv", 32'(bus.wb_valid), 32'd0);
        chk("mid_rst_r1", 32'(bus.dbg_data), 32'd0);
        chk("mid_rst_div0", 32'(bus.div0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_wb", 32'(bus.wb_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus.dbg_addr = 3'd6;
        #1;
        chk("rst_r6", 32'(bus.dbg_data), 32'd0);
        issue(mk(3'd2, 3'd1, 3'd0, 3'd0, 1'b1, 11'd9));
        for (int i = 0; i < 10; i++) issue(24'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
